// File: rtl/motoro3_pkg.sv
// Shared types, constants and phase-offset helper for the motoro3 step generator.
package motoro3_pkg;

    typedef enum logic [0:0] {
        M3_IDLE,
        M3_RUN
    } m3_state_e;

    localparam logic [31:0] STEP_IDLE_CODE = 32'hFFFF_FFFF;

    localparam int unsigned PERIOD_INIT_SYN  = 1666667;
    localparam int unsigned PERIOD_MIN_SYN   = 1667;
    localparam int unsigned PERIOD_MAX_SYN   = 16666667;
    localparam int unsigned PERIOD_DELTA_SYN = 1000;

    localparam int unsigned PERIOD_INIT_SIM  = 4;
    localparam int unsigned PERIOD_MIN_SIM   = 2;
    localparam int unsigned PERIOD_MAX_SIM   = 8;
    localparam int unsigned PERIOD_DELTA_SIM = 2;

    // Step a (1..n) shifted forward by off steps; idle/out-of-range maps to all-ones.
    function automatic logic [31:0] step_offset(input int unsigned a, input int unsigned off,
                                                input int unsigned n);
        if (a == 0 || a > n) begin
            return STEP_IDLE_CODE;
        end
        return (a - 1 + off) % n + 1;
    endfunction

endpackage

// File: rtl/motoro3_period_ctrl.sv
// Step-period register: INC/DEC edge detection with clamping, plus the optional
// soft-start ramp (M3_SOFTSTART_EN).
module motoro3_period_ctrl
    import motoro3_pkg::*;
#(
    parameter int unsigned CNT_W        = 25,
    parameter int unsigned PERIOD_INIT  = PERIOD_INIT_SYN,
    parameter int unsigned PERIOD_MIN   = PERIOD_MIN_SYN,
    parameter int unsigned PERIOD_MAX   = PERIOD_MAX_SYN,
    parameter int unsigned PERIOD_DELTA = PERIOD_DELTA_SYN
) (
    input  logic             clk_i,
    input  logic             nRst,
    input  logic             inc_i,
    input  logic             dec_i,
`ifdef M3_SOFTSTART_EN
    input  logic             start_load_i,
    input  logic             round_wrap_i,
    output logic             ramping_o,
`endif
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] period_nxt_o
);

    localparam logic [CNT_W-1:0] PInit  = CNT_W'(PERIOD_INIT);
    localparam logic [CNT_W-1:0] PMin   = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] PMax   = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] PDelta = CNT_W'(PERIOD_DELTA);

    logic             inc_q, dec_q, inc_up, dec_up;
    logic [CNT_W-1:0] period_q, period_d, period_dn, period_up;

    assign inc_up = inc_i & ~inc_q;
    assign dec_up = dec_i & ~dec_q;

    // Compare one bit wider so the clamps never wrap.
    assign period_dn = ({1'b0, period_q} < ({1'b0, PMin} + {1'b0, PDelta})) ? PMin
                                                                             : period_q - PDelta;
    assign period_up = (({1'b0, period_q} + {1'b0, PDelta}) > {1'b0, PMax}) ? PMax
                                                                             : period_q + PDelta;

`ifdef M3_SOFTSTART_EN
    logic             ramping_q, ramping_d;
    logic [CNT_W-1:0] period_ramp;

    assign period_ramp = ({1'b0, period_q} < ({1'b0, PInit} + {1'b0, PDelta})) ? PInit
                                                                                : period_q - PDelta;

    always_comb begin
        period_d  = period_q;
        ramping_d = ramping_q;
        if (start_load_i) begin
            period_d  = PMax;
            ramping_d = (PMax != PInit);
        end else if (ramping_q) begin
            if (round_wrap_i) begin
                period_d  = period_ramp;
                ramping_d = (period_ramp != PInit);
            end
        end else if (inc_up && !dec_up) begin
            period_d = period_dn;
        end else if (dec_up && !inc_up) begin
            period_d = period_up;
        end
    end

    always_ff @(negedge clk_i or negedge nRst) begin
        if (!nRst) begin
            ramping_q <= 1'b0;
        end else begin
            ramping_q <= ramping_d;
        end
    end

    assign ramping_o = ramping_q;
`else
    always_comb begin
        period_d = period_q;
        if (inc_up && !dec_up) begin
            period_d = period_dn;
        end else if (dec_up && !inc_up) begin
            period_d = period_up;
        end
    end
`endif

    always_ff @(negedge clk_i or negedge nRst) begin
        if (!nRst) begin
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            period_q <= PInit;
        end else begin
            inc_q    <= inc_i;
            dec_q    <= dec_i;
            period_q <= period_d;
        end
    end

    assign period_o     = period_q;
    assign period_nxt_o = period_d;

endmodule

// File: rtl/motoro3_step_gen_ramp.sv
// Three-phase commutation step generator with adjustable period, direction and
// saturating round counter. Optional soft-start ramp under M3_SOFTSTART_EN.
module motoro3_step_gen_ramp
    import motoro3_pkg::*;
#(
    parameter int unsigned CNT_W        = 25,
    parameter int unsigned STEP_N       = 12,
    parameter int unsigned STEP_W       = 4,
    parameter int unsigned PERIOD_INIT  = PERIOD_INIT_SYN,
    parameter int unsigned PERIOD_MIN   = PERIOD_MIN_SYN,
    parameter int unsigned PERIOD_MAX   = PERIOD_MAX_SYN,
    parameter int unsigned PERIOD_DELTA = PERIOD_DELTA_SYN,
    parameter int unsigned ROUND_W      = 32
) (
    input  logic               clk_i,
    input  logic               nRst,
    input  logic               m3start_i,
    input  logic               m3dir_i,
    input  logic               m3freqINC_i,
    input  logic               m3freqDEC_i,
    output logic [STEP_W-1:0]  m3stepA_o,
    output logic [STEP_W-1:0]  m3stepB_o,
    output logic [STEP_W-1:0]  m3stepC_o,
    output logic [CNT_W-1:0]   m3cnt_o,
    output logic [CNT_W-1:0]   m3period_o,
    output logic               m3cntLast1_o,
    output logic               m3stepTick_o,
`ifdef M3_SOFTSTART_EN
    output logic               m3ramping_o,
`endif
    output logic [ROUND_W-1:0] m3roundCNT_o
);

    localparam logic [STEP_W-1:0] StepN   = STEP_W'(STEP_N);
    localparam logic [STEP_W-1:0] StepOne = STEP_W'(1);

    m3_state_e          state_q;
    logic               start_q, tick_q;
    logic [STEP_W-1:0]  step_a_q, step_a_nxt;
    logic [CNT_W-1:0]   cnt_q, period_q, period_nxt;
    logic [ROUND_W-1:0] round_q;
    logic               start_up, last1, wrap;

    assign start_up = m3start_i & ~start_q;
    assign last1    = (cnt_q[CNT_W-1:1] == '0);

    always_comb begin
        if (m3dir_i) begin
            wrap       = (step_a_q <= StepOne);
            step_a_nxt = wrap ? StepN : step_a_q - StepOne;
        end else begin
            wrap       = (step_a_q >= StepN);
            step_a_nxt = wrap ? StepOne : step_a_q + StepOne;
        end
    end

    motoro3_period_ctrl #(
        .CNT_W        (CNT_W),
        .PERIOD_INIT  (PERIOD_INIT),
        .PERIOD_MIN   (PERIOD_MIN),
        .PERIOD_MAX   (PERIOD_MAX),
        .PERIOD_DELTA (PERIOD_DELTA)
    ) u_period_ctrl (
        .clk_i        (clk_i),
        .nRst         (nRst),
        .inc_i        (m3freqINC_i),
        .dec_i        (m3freqDEC_i),
`ifdef M3_SOFTSTART_EN
        .start_load_i (start_up & (state_q == M3_IDLE)),
        .round_wrap_i ((state_q == M3_RUN) & m3start_i & last1 & wrap),
        .ramping_o    (m3ramping_o),
`endif
        .period_o     (period_q),
        .period_nxt_o (period_nxt)
    );

    // Every reload takes the period as it stands after this edge, so m3cnt and
    // m3period agree right after each step boundary.
    always_ff @(negedge clk_i or negedge nRst) begin
        if (!nRst) begin
            state_q  <= M3_IDLE;
            start_q  <= 1'b0;
            tick_q   <= 1'b0;
            step_a_q <= '0;
            cnt_q    <= CNT_W'(PERIOD_INIT);
            round_q  <= '0;
        end else begin
            start_q <= m3start_i;
            tick_q  <= 1'b0;
            unique case (state_q)
                M3_IDLE: begin
                    cnt_q   <= period_nxt;
                    round_q <= '0;
                    if (start_up) begin
                        state_q  <= M3_RUN;
                        step_a_q <= StepOne;
                        tick_q   <= 1'b1;
                    end else begin
                        step_a_q <= '0;
                    end
                end
                M3_RUN: begin
                    if (!m3start_i) begin
                        state_q  <= M3_IDLE;
                        step_a_q <= '0;
                        cnt_q    <= period_nxt;
                        round_q  <= '0;
                    end else if (last1) begin
                        step_a_q <= step_a_nxt;
                        cnt_q    <= period_nxt;
                        tick_q   <= 1'b1;
                        if (wrap && (round_q != '1)) begin
                            round_q <= round_q + ROUND_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= M3_IDLE;
            endcase
        end
    end

    assign m3stepA_o    = step_a_q;
    assign m3stepB_o    = STEP_W'(step_offset(32'(step_a_q), (2 * STEP_N) / 3, STEP_N));
    assign m3stepC_o    = STEP_W'(step_offset(32'(step_a_q), STEP_N / 3, STEP_N));
    assign m3cnt_o      = cnt_q;
    assign m3period_o   = period_q;
    assign m3cntLast1_o = last1;
    assign m3stepTick_o = tick_q;
    assign m3roundCNT_o = round_q;

endmodule
